// File: rtl/runner_arbiter_if.sv
// Handshake bundle between NUM_REQ requesters and the shared runner output stage.
// The req_last lane exists only when RUNNER_ARB_LOCK_EN is defined.
interface runner_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH_IN  = 4,
  parameter int WIDTH_OUT = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*WIDTH_IN-1:0] req_data;
  logic [NUM_REQ-1:0]          req_ready;
`ifdef RUNNER_ARB_LOCK_EN
  logic [NUM_REQ-1:0]          req_last;
`endif
  logic                        out_valid;
  logic                        out_ready;
  logic [WIDTH_OUT-1:0]        out_data;
  logic [ID_W-1:0]             out_id;
  logic                        busy;

`ifdef RUNNER_ARB_LOCK_EN
  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_id, busy
  );
  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_id, busy
  );
`else
  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id, busy
  );
  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id, busy
  );
`endif
endinterface

// File: rtl/runner_arbiter.sv
// Round-robin arbiter feeding one registered, zero-extending output stage tagged with source id.
// Define RUNNER_ARB_LOCK_EN to add req_last-based multi-beat locking (LOCKED state).
module runner_arbiter #(
  parameter int  NUM_REQ   = 4,
  parameter int  WIDTH_IN  = 4,
  parameter int  WIDTH_OUT = 8,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input logic             clk,
  input logic             reset,
  runner_arbiter_if.slave bus
);

  generate
    if (WIDTH_OUT < WIDTH_IN) begin : g_width_check
      $error("runner_arbiter: WIDTH_OUT must be >= WIDTH_IN");
    end
    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_num_req_check
      $error("runner_arbiter: NUM_REQ must be within 2..16");
    end
  endgenerate

`ifdef RUNNER_ARB_LOCK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, LOCKED = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;
`endif

  state_t              state_q;
  state_t              state_d;
  state_t              accept_state;
  logic [ID_W-1:0]     last_grant;
  logic [ID_W-1:0]     winner;
  logic [ID_W-1:0]     scan_idx;
  logic                found;
  logic                space;
  logic                accept;
  logic                lock_mode;
  logic [WIDTH_IN-1:0] winner_data;

  assign space  = !bus.out_valid || bus.out_ready;
  assign accept = found && space && !reset;

`ifdef RUNNER_ARB_LOCK_EN
  // While locked, last_grant always names the locked requester.
  assign lock_mode    = (state_q == LOCKED);
  assign accept_state = bus.req_last[winner] ? HOLD : LOCKED;
`else
  assign lock_mode    = 1'b0;
  assign accept_state = HOLD;
`endif

  always_comb begin
    found    = 1'b0;
    winner   = last_grant;
    scan_idx = last_grant;
    if (lock_mode) begin
      found = bus.req_valid[last_grant];
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = ID_W'((int'(last_grant) + 1 + k) % NUM_REQ);
        if (!found && bus.req_valid[scan_idx]) begin
          found  = 1'b1;
          winner = scan_idx;
        end
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (accept) begin
      bus.req_ready[winner] = 1'b1;
    end
  end

  assign winner_data = bus.req_data[int'(winner)*WIDTH_IN +: WIDTH_IN];
  assign bus.busy    = bus.out_valid || lock_mode;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = accept_state;
      end
      HOLD: begin
        if (accept) state_d = accept_state;
        else if (bus.out_ready) state_d = IDLE;
      end
`ifdef RUNNER_ARB_LOCK_EN
      LOCKED: begin
        if (accept && bus.req_last[winner]) state_d = HOLD;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // A simultaneous drain and accept simply overwrites the held beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_id    <= '0;
      last_grant    <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      if (accept) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= WIDTH_OUT'(winner_data);
        bus.out_id    <= winner;
        last_grant    <= winner;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_runner_arbiter.sv
// Scoreboard bench for runner_arbiter: directed stimulus pushes expected beats, a negedge monitor pops them.
// The lock sequence is exercised only when RUNNER_ARB_LOCK_EN is defined.
module tb_runner_arbiter;

  logic clk;
  logic reset;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_beat;
  int    vectors;
  int    miscompares;

  runner_arbiter_if #(.NUM_REQ(4), .WIDTH_IN(4), .WIDTH_OUT(8)) bus ();

  runner_arbiter #(
    .NUM_REQ  (4),
    .WIDTH_IN (4),
    .WIDTH_OUT(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change 1ns after the rising edge so every edge samples a settled vector.
  task automatic applyStimulus(input logic [3:0] valid, input logic [15:0] data, input logic ready);
    @(posedge clk);
    #1;
    bus.req_valid = valid;
    bus.req_data  = data;
    bus.out_ready = ready;
  endtask

  task automatic pushBeat(input logic [1:0] id, input logic [7:0] data);
    beat_t b;
    b.id   = id;
    b.data = data;
    exp_q.push_back(b);
  endtask

  // Each beat leaving the output stage must be the oldest expected one.
  always @(negedge clk) begin
    if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_beat: got id=%0d data=%0h, expected no beat", bus.out_id, bus.out_data);
      end else begin
        mon_beat = exp_q.pop_front();
        checkOutput("beat_id", 32'(bus.out_id), 32'(mon_beat.id));
        checkOutput("beat_data", 32'(bus.out_data), 32'(mon_beat.data));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_data  = 16'hDCBA;
    bus.out_ready = 1'b0;
`ifdef RUNNER_ARB_LOCK_EN
    bus.req_last  = 4'b1111;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_req_ready", 32'(bus.req_ready), 32'h0);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("reset_out_data", 32'(bus.out_data), 32'h00);
    checkOutput("reset_out_id", 32'(bus.out_id), 32'h0);
    checkOutput("reset_busy", 32'(bus.busy), 32'h0);

    // Round robin, all requesters valid, data A,B,C,D.
    applyStimulus(4'b1111, 16'hDCBA, 1'b1);
    reset = 1'b0;
    for (int r = 0; r < 2; r++) begin
      pushBeat(2'd0, 8'h0A);
      pushBeat(2'd1, 8'h0B);
      pushBeat(2'd2, 8'h0C);
      pushBeat(2'd3, 8'h0D);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("rr_req_ready", 32'(bus.req_ready), 32'(4'b0001 << (i % 4)));
      if (i < 7) applyStimulus(4'b1111, 16'hDCBA, 1'b1);
    end
    applyStimulus(4'b0000, 16'h0000, 1'b1);

    // Backpressure on requester 2; its data changes while stalled.
    applyStimulus(4'b0100, 16'h0500, 1'b0);
    pushBeat(2'd2, 8'h05);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0100, 16'h0600, 1'b0);
      @(negedge clk);
      checkOutput("bp_out_valid", 32'(bus.out_valid), 32'h1);
      checkOutput("bp_out_data", 32'(bus.out_data), 32'h05);
      checkOutput("bp_out_id", 32'(bus.out_id), 32'h2);
      checkOutput("bp_req_ready", 32'(bus.req_ready), 32'h0);
      checkOutput("bp_busy", 32'(bus.busy), 32'h1);
    end
    applyStimulus(4'b0100, 16'h0600, 1'b1);
    pushBeat(2'd2, 8'h06);
    @(negedge clk);
    checkOutput("bp_release_req_ready", 32'(bus.req_ready), 32'b0100);
    applyStimulus(4'b0000, 16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("bp_next_out_data", 32'(bus.out_data), 32'h06);

    // Sparse requests and wrap-around from last_grant=3.
    applyStimulus(4'b1000, 16'hE000, 1'b1);
    pushBeat(2'd3, 8'h0E);
    @(negedge clk);
    checkOutput("sparse_req_ready_3", 32'(bus.req_ready), 32'b1000);
    applyStimulus(4'b0100, 16'h0300, 1'b1);
    pushBeat(2'd2, 8'h03);
    @(negedge clk);
    checkOutput("wrap_req_ready_2", 32'(bus.req_ready), 32'b0100);
    applyStimulus(4'b0101, 16'h0301, 1'b1);
    pushBeat(2'd0, 8'h01);
    @(negedge clk);
    checkOutput("wrap_req_ready_0", 32'(bus.req_ready), 32'b0001);
    applyStimulus(4'b0101, 16'h0301, 1'b1);
    pushBeat(2'd2, 8'h03);
    @(negedge clk);
    checkOutput("wrap_req_ready_2b", 32'(bus.req_ready), 32'b0100);
    applyStimulus(4'b0000, 16'h0000, 1'b1);

    // Held beat discarded by reset; priority returns to requester 0.
    applyStimulus(4'b0010, 16'h0090, 1'b0);
    applyStimulus(4'b0000, 16'h0000, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_held_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("midreset_req_ready", 32'(bus.req_ready), 32'h0);
    applyStimulus(4'b1111, 16'h4321, 1'b1);
    reset = 1'b0;
    pushBeat(2'd0, 8'h01);
    @(negedge clk);
    checkOutput("midreset_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("midreset_busy", 32'(bus.busy), 32'h0);
    checkOutput("midreset_priority", 32'(bus.req_ready), 32'b0001);
    applyStimulus(4'b0000, 16'h0000, 1'b1);

`ifdef RUNNER_ARB_LOCK_EN
    // Requester 1 locks for three beats while 0 and 3 stay valid.
    applyStimulus(4'b1011, 16'h4021, 1'b1);
    bus.req_last = 4'b1101;
    pushBeat(2'd1, 8'h02);
    applyStimulus(4'b1011, 16'h4021, 1'b1);
    pushBeat(2'd1, 8'h02);
    @(negedge clk);
    checkOutput("lock_busy", 32'(bus.busy), 32'h1);
    applyStimulus(4'b1011, 16'h4021, 1'b1);
    bus.req_last = 4'b1111;
    pushBeat(2'd1, 8'h02);
    applyStimulus(4'b1011, 16'h4021, 1'b1);
    pushBeat(2'd3, 8'h04);
    applyStimulus(4'b1011, 16'h4021, 1'b1);
    pushBeat(2'd0, 8'h01);
    applyStimulus(4'b0000, 16'h0000, 1'b1);
`endif

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
    @(negedge clk);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
